// File: rtl/spi_protocol_monitor.sv
// Passive SPI bus monitor: decodes MOSI frames, captures MISO read-data and
// flags protocol violations with saturating error and wrapping frame counters.
module spi_protocol_monitor #(
  parameter int               CMD_W       = 2,
  parameter int               DATA_W      = 8,
  parameter logic [CMD_W-1:0] RD_DATA_CMD = 2'b11,
  parameter int               RD_LATENCY  = 1,
  parameter int               TIMEOUT_CYC = 16,
  parameter int               CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chk_en,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic              MISO,
  output logic              frame_valid,
  output logic [CMD_W-1:0]  frame_cmd,
  output logic [DATA_W-1:0] frame_data,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              err_reset_miso,
  output logic              err_miso_unstable,
  output logic              err_short_frame,
  output logic              err_long_frame,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  frame_count
);

  localparam int FRAME_W = CMD_W + DATA_W;
  localparam int CW      = $clog2(FRAME_W + DATA_W + RD_LATENCY + TIMEOUT_CYC + 2) + 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CMD_DATA = 3'd1;
  localparam logic [2:0] S_RD_WAIT  = 3'd2;
  localparam logic [2:0] S_RD_DATA  = 3'd3;
  localparam logic [2:0] S_HOLD     = 3'd4;

  localparam logic [CW-1:0]    CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]    FRAME_LAST = CW'(FRAME_W - 1);
  localparam logic [CW-1:0]    DATA_LAST  = CW'(DATA_W - 1);
  localparam logic [CW-1:0]    WAIT_LAST  = CW'(RD_LATENCY - 1);
  localparam logic [CW-1:0]    TO_LIM     = CW'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] FCNT_ONE   = CNT_W'(1);

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rshift_q, rshift_d;
  logic              ss_prev_q, miso_prev_q, first_cycle_q;
  logic              frame_valid_q, frame_valid_d;
  logic [CMD_W-1:0]  frame_cmd_q, frame_cmd_d;
  logic [DATA_W-1:0] frame_data_q, frame_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              err_rst_q, err_uns_q, err_short_q, err_long_q;
  logic              err_rst_d, err_uns_d, err_short_d, err_long_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [CNT_W-1:0]  frame_count_q, frame_count_d;

  logic [FRAME_W-1:0] frame_s;
  logic [DATA_W-1:0]  rd_frame_s;
  logic               short_s, long_s, unstable_s, rst_miso_s;
  logic [2:0]         n_err_s;
  logic [CNT_W:0]     err_sum_s;

  assign frame_s    = {shift_q[FRAME_W-2:0], MOSI};
  assign rd_frame_s = {rshift_q[DATA_W-2:0], MISO};

  // Frame decoder FSM next-state logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    rshift_d      = rshift_q;
    frame_valid_d = 1'b0;
    frame_cmd_d   = frame_cmd_q;
    frame_data_d  = frame_data_q;
    frame_count_d = frame_count_q;
    rd_valid_d    = 1'b0;
    rd_data_d     = rd_data_q;
    short_s       = 1'b0;
    long_s        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!SS_n && ss_prev_q) begin
          state_d = S_CMD_DATA;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMD_DATA: begin
        if (SS_n) begin
          short_s = 1'b1;
          state_d = S_IDLE;
        end else begin
          shift_d = frame_s;
          if (cnt_q == FRAME_LAST) begin
            frame_cmd_d   = frame_s[FRAME_W-1 -: CMD_W];
            frame_data_d  = frame_s[DATA_W-1:0];
            frame_valid_d = 1'b1;
            frame_count_d = frame_count_q + FCNT_ONE;
            cnt_d         = CNT_ZERO;
            if (frame_s[FRAME_W-1 -: CMD_W] == RD_DATA_CMD) begin
              state_d = (RD_LATENCY == 0) ? S_RD_DATA : S_RD_WAIT;
            end else begin
              state_d = S_HOLD;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_RD_WAIT: begin
        if (SS_n) begin
          short_s = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_RD_DATA;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RD_DATA: begin
        if (SS_n) begin
          short_s = 1'b1;
          state_d = S_IDLE;
        end else begin
          rshift_d = rd_frame_s;
          if (cnt_q == DATA_LAST) begin
            rd_data_d  = rd_frame_s;
            rd_valid_d = 1'b1;
            state_d    = S_HOLD;
            cnt_d      = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_HOLD: begin
        if (SS_n) begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q <= TO_LIM) begin
          // Counter parks at TO_LIM+1 so the timeout fires only once.
          cnt_d  = cnt_q + CNT_ONE;
          long_s = (cnt_q == TO_LIM);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Error qualification and saturating error accumulation.
  always_comb begin
    unstable_s  = !SS_n && (state_q != S_RD_DATA) && (MISO != miso_prev_q);
    rst_miso_s  = first_cycle_q && MISO;
    err_rst_d   = chk_en && rst_miso_s;
    err_uns_d   = chk_en && unstable_s;
    err_short_d = chk_en && short_s;
    err_long_d  = chk_en && long_s;
    n_err_s     = {2'b00, err_rst_d} + {2'b00, err_uns_d} +
                  {2'b00, err_short_d} + {2'b00, err_long_d};
    err_sum_s   = {1'b0, err_count_q} + (CNT_W+1)'(n_err_s);
    if (err_sum_s[CNT_W]) begin
      err_count_d = {CNT_W{1'b1}};
    end else begin
      err_count_d = err_sum_s[CNT_W-1:0];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= CNT_ZERO;
      shift_q       <= '0;
      rshift_q      <= '0;
      ss_prev_q     <= 1'b0;
      miso_prev_q   <= 1'b0;
      first_cycle_q <= 1'b1;
      frame_valid_q <= 1'b0;
      frame_cmd_q   <= '0;
      frame_data_q  <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      err_rst_q     <= 1'b0;
      err_uns_q     <= 1'b0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
      err_count_q   <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      rshift_q      <= rshift_d;
      ss_prev_q     <= SS_n;
      miso_prev_q   <= MISO;
      first_cycle_q <= 1'b0;
      frame_valid_q <= frame_valid_d;
      frame_cmd_q   <= frame_cmd_d;
      frame_data_q  <= frame_data_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      err_rst_q     <= err_rst_d;
      err_uns_q     <= err_uns_d;
      err_short_q   <= err_short_d;
      err_long_q    <= err_long_d;
      err_count_q   <= err_count_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_valid       = frame_valid_q;
  assign frame_cmd         = frame_cmd_q;
  assign frame_data        = frame_data_q;
  assign rd_data_valid     = rd_valid_q;
  assign rd_data           = rd_data_q;
  assign err_reset_miso    = err_rst_q;
  assign err_miso_unstable = err_uns_q;
  assign err_short_frame   = err_short_q;
  assign err_long_frame    = err_long_q;
  assign err_count         = err_count_q;
  assign frame_count       = frame_count_q;

endmodule
